// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the DVP pixel capture path
//
// Holds the default frame geometry, the capture state encoding, the pixel
// record handed to the frame buffer writer, and the bit layout of the raw
// DVP bus as it passes through the input synchronizer.
package cam_pkg;

    localparam int HRES_DEFAULT = 1280;
    localparam int VRES_DEFAULT = 720;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    // Raw DVP bus packing: {vsync, href, pclk, data[7:0]}
    localparam int BUS_W     = 11;
    localparam int BUS_PCLK  = 8;
    localparam int BUS_HREF  = 9;
    localparam int BUS_VSYNC = 10;

    typedef enum logic [1:0] {
        WAIT_CFG   = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } capture_state_t;

    typedef struct packed {
        logic [15:0]         data;
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
    } cam_pixel_t;

endpackage

// File: rtl/cam_input_sync.sv
// rtl/cam_input_sync.sv - 2-flop synchronizer plus history register for the DVP pins
//
// Ports:
//   clk_i       camera-domain clock
//   rst_i       asynchronous active-high reset
//   bus_i       raw asynchronous input bus
//   sync_o      synchronized bus (second flop)
//   hist_o      synchronized bus delayed by one cycle
//   pclk_rise_o high for one cycle when the synced PCLK bit rises
module cam_input_sync
    import cam_pkg::*;
#(
    parameter int W        = BUS_W,
    parameter int PCLK_BIT = BUS_PCLK
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] bus_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] hist_o,
    output logic         pclk_rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= bus_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_o      = sync_q;
    assign hist_o      = hist_q;
    assign pclk_rise_o = sync_q[PCLK_BIT] & ~hist_q[PCLK_BIT];

endmodule

// File: rtl/camera_pixel_capture.sv
// rtl/camera_pixel_capture.sv - DVP byte-pair to RGB565 pixel capture with coordinates
//
// Ports:
//   clk_camera      camera-domain clock, at least 3x PCLK
//   sys_rst_camera  asynchronous active-high reset
//   cfg_done        level, camera configuration complete
//   cam_pclk_i      raw DVP pixel clock
//   cam_href_i      raw DVP line-active
//   cam_vsync_i     raw DVP vsync
//   cam_data_i      raw DVP data byte
//   pixel_valid     one-cycle strobe, pixel outputs valid
//   pixel_data      RGB565, first byte in [15:8]
//   pixel_hcount    column of the pixel
//   pixel_vcount    row of the pixel
//   frame_done      one-cycle pulse at end of a captured frame
//   capture_error   sticky protocol error flag
module camera_pixel_capture
    import cam_pkg::*;
#(
    parameter int HRES = HRES_DEFAULT,
    parameter int VRES = VRES_DEFAULT
) (
    input  logic                clk_camera,
    input  logic                sys_rst_camera,
    input  logic                cfg_done,
    input  logic                cam_pclk_i,
    input  logic                cam_href_i,
    input  logic                cam_vsync_i,
    input  logic [7:0]          cam_data_i,
    output logic                pixel_valid,
    output logic [15:0]         pixel_data,
    output logic [HCOUNT_W-1:0] pixel_hcount,
    output logic [VCOUNT_W-1:0] pixel_vcount,
    output logic                frame_done,
    output logic                capture_error
);

    localparam logic [HCOUNT_W-1:0] HRES_C = HCOUNT_W'(HRES);
    localparam logic [VCOUNT_W-1:0] VRES_C = VCOUNT_W'(VRES);

    logic [BUS_W-1:0] sync_bus;
    logic [BUS_W-1:0] hist_bus;
    logic             pclk_rise;

    cam_input_sync #(
        .W        (BUS_W),
        .PCLK_BIT (BUS_PCLK)
    ) u_sync (
        .clk_i       (clk_camera),
        .rst_i       (sys_rst_camera),
        .bus_i       ({cam_vsync_i, cam_href_i, cam_pclk_i, cam_data_i}),
        .sync_o      (sync_bus),
        .hist_o      (hist_bus),
        .pclk_rise_o (pclk_rise)
    );

    logic unused_sync_bits;
    assign unused_sync_bits = ^{sync_bus[BUS_PCLK], hist_bus[BUS_PCLK:0]};

    // Edge-detect stage: every event and the byte that goes with it are
    // registered together, so the FSM sees one coherent snapshot per cycle.
    logic       edge_q;
    logic       href_q;
    logic       href_fall_q;
    logic       vs_rise_q;
    logic       vs_fall_q;
    logic       vs_prev_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            edge_q      <= 1'b0;
            href_q      <= 1'b0;
            href_fall_q <= 1'b0;
            vs_rise_q   <= 1'b0;
            vs_fall_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            byte_q      <= '0;
        end else begin
            edge_q      <= pclk_rise;
            href_q      <= sync_bus[BUS_HREF];
            href_fall_q <= hist_bus[BUS_HREF] & ~sync_bus[BUS_HREF];
            vs_rise_q   <= ~hist_bus[BUS_VSYNC] & sync_bus[BUS_VSYNC];
            vs_fall_q   <= hist_bus[BUS_VSYNC] & ~sync_bus[BUS_VSYNC];
            vs_prev_q   <= hist_bus[BUS_VSYNC];
            byte_q      <= sync_bus[7:0];
        end
    end

    capture_state_t      state_q;
    logic                phase_q;
    logic [7:0]          hi_q;
    logic [HCOUNT_W-1:0] hcount_q;
    logic [VCOUNT_W-1:0] vcount_q;
    logic                pend_q;
    cam_pixel_t          pix_q;
    logic                valid_q;
    logic                done_q;
    logic                err_q;

    // Gating on the previous VSYNC sample lets a byte that coincides with the
    // VSYNC rise still be captured, while HREF inside the VSYNC pulse is ignored.
    logic pix_accept;
    assign pix_accept = edge_q & href_q & ~vs_prev_q;

    // A line still open at frame end (HREF fall not yet seen) counts as a row.
    logic [VCOUNT_W-1:0] vcount_end_d;
    logic                open_line_bad_d;
    assign vcount_end_d    = vcount_q + {{(VCOUNT_W-1){1'b0}}, (hcount_q != '0)};
    assign open_line_bad_d = phase_q | ((hcount_q != '0) & (hcount_q != HRES_C));

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            state_q  <= WAIT_CFG;
            phase_q  <= 1'b0;
            hi_q     <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            pend_q   <= 1'b0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (!cfg_done) begin
                state_q <= WAIT_CFG;
                pend_q  <= 1'b0;
                phase_q <= 1'b0;
            end else begin
                unique case (state_q)
                    WAIT_CFG: state_q <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        if (vs_fall_q) begin
                            state_q  <= ACTIVE;
                            hcount_q <= '0;
                            vcount_q <= '0;
                            phase_q  <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (pend_q) begin
                            // Frame end is deferred one cycle so a pixel on the
                            // VSYNC-rise cycle is emitted before frame_done.
                            pend_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= WAIT_FRAME;
                            hcount_q <= '0;
                            phase_q  <= 1'b0;
                            if (vcount_end_d != VRES_C || open_line_bad_d) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            if (vs_rise_q) begin
                                pend_q <= 1'b1;
                            end
                            if (pix_accept) begin
                                if (!phase_q) begin
                                    hi_q    <= byte_q;
                                    phase_q <= 1'b1;
                                end else begin
                                    phase_q <= 1'b0;
                                    if (hcount_q < HRES_C && vcount_q < VRES_C) begin
                                        valid_q     <= 1'b1;
                                        pix_q.data   <= {hi_q, byte_q};
                                        pix_q.hcount <= hcount_q;
                                        pix_q.vcount <= vcount_q;
                                        hcount_q     <= hcount_q + 1'b1;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                            end else if (href_fall_q && !vs_prev_q) begin
                                hcount_q <= '0;
                                phase_q  <= 1'b0;
                                if (hcount_q != '0 && vcount_q < VRES_C) begin
                                    vcount_q <= vcount_q + 1'b1;
                                end
                                if (phase_q || hcount_q != HRES_C) begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= WAIT_CFG;
                endcase
            end
        end
    end

    assign pixel_valid   = valid_q;
    assign pixel_data    = pix_q.data;
    assign pixel_hcount  = pix_q.hcount;
    assign pixel_vcount  = pix_q.vcount;
    assign frame_done    = done_q;
    assign capture_error = err_q;

endmodule

// File: tb/tb_camera_pixel_capture.sv
// tb/tb_camera_pixel_capture.sv - directed self-checking bench for camera_pixel_capture
module tb_camera_pixel_capture;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        cfg_done = 1'b0;
    logic        pclk     = 1'b0;
    logic        href     = 1'b0;
    logic        vsync    = 1'b0;
    logic [7:0]  data     = 8'h00;

    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic [10:0] pixel_hcount;
    logic [9:0]  pixel_vcount;
    logic        frame_done;
    logic        capture_error;

    camera_pixel_capture #(
        .HRES (4),
        .VRES (2)
    ) dut (
        .clk_camera     (clk),
        .sys_rst_camera (rst),
        .cfg_done       (cfg_done),
        .cam_pclk_i     (pclk),
        .cam_href_i     (href),
        .cam_vsync_i    (vsync),
        .cam_data_i     (data),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .pixel_hcount   (pixel_hcount),
        .pixel_vcount   (pixel_vcount),
        .frame_done     (frame_done),
        .capture_error  (capture_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int errors   = 0;
    int rise_cyc = 0;
    int kbyte    = 0;

    logic [15:0] pix_d[$];
    logic [10:0] pix_h[$];
    logic [9:0]  pix_v[$];
    int          pix_c[$];
    int          pix_lat[$];
    int          fd_n = 0;
    int          fd_c = 0;

    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            pix_d.push_back(pixel_data);
            pix_h.push_back(pixel_hcount);
            pix_v.push_back(pixel_vcount);
            pix_c.push_back(cyc);
            pix_lat.push_back(cyc - rise_cyc);
        end
        if (frame_done === 1'b1) begin
            fd_n = fd_n + 1;
            fd_c = cyc;
        end
    end

    function automatic logic [31:0] qd(input int i);
        return (i < pix_d.size()) ? 32'(pix_d[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qh(input int i);
        return (i < pix_h.size()) ? 32'(pix_h[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qv(input int i);
        return (i < pix_v.size()) ? 32'(pix_v[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qc(input int i);
        return (i < pix_c.size()) ? 32'(pix_c[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ql(input int i);
        return (i < pix_lat.size()) ? 32'(pix_lat[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte();
        data  = 8'(32'h12 + kbyte * 34);
        kbyte = kbyte + 1;
        pclk  = 1'b0;
        tick(3);
        pclk     = 1'b1;
        rise_cyc = cyc;
        tick(3);
    endtask

    task automatic send_line(input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) send_byte();
        pclk = 1'b0;
        href = 1'b0;
        tick(10);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick(10);
        vsync = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick(2);
    endtask

    int b;
    int f;

    initial begin
        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(pixel_valid), 32'h0);
        chk("rst_data", 32'(pixel_data), 32'h0);
        chk("rst_hcount", 32'(pixel_hcount), 32'h0);
        chk("rst_vcount", 32'(pixel_vcount), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_error", 32'(capture_error), 32'h0);
        #2 rst = 1'b0;
        tick(2);

        // Small 4x2 frame
        cfg_done = 1'b1;
        tick(3);
        vsync_pulse();
        kbyte = 0;
        b = pix_d.size();
        f = fd_n;
        send_line(8);
        send_line(8);
        vsync_pulse();
        chk("t1_count", 32'(pix_d.size() - b), 32'd8);
        chk("t1_latency", ql(b), 32'd4);
        chk("t1_first_data", qd(b), 32'h1234);
        chk("t1_first_h", qh(b), 32'd0);
        chk("t1_first_v", qv(b), 32'd0);
        chk("t1_line2_data", qd(b + 4), 32'h2244);
        chk("t1_line2_h", qh(b + 4), 32'd0);
        chk("t1_line2_v", qv(b + 4), 32'd1);
        chk("t1_last_data", qd(b + 7), 32'hEE10);
        chk("t1_last_h", qh(b + 7), 32'd3);
        chk("t1_last_v", qv(b + 7), 32'd1);
        chk("t1_frame_done", 32'(fd_n - f), 32'd1);
        chk("t1_error", 32'(capture_error), 32'h0);

        // Frame before cfg_done
        do_reset();
        cfg_done = 1'b0;
        b = pix_d.size();
        f = fd_n;
        vsync_pulse();
        send_line(8);
        cfg_done = 1'b1;
        send_line(8);
        chk("t2_no_pixels", 32'(pix_d.size() - b), 32'd0);
        vsync_pulse();
        chk("t2_no_frame_done", 32'(fd_n - f), 32'd0);
        kbyte = 0;
        send_line(8);
        chk("t2_count", 32'(pix_d.size() - b), 32'd4);
        chk("t2_first_data", qd(b), 32'h1234);
        chk("t2_first_v", qv(b), 32'd0);

        // Odd byte count line
        do_reset();
        vsync_pulse();
        b = pix_d.size();
        send_line(7);
        chk("t3_count", 32'(pix_d.size() - b), 32'd3);
        chk("t3_error", 32'(capture_error), 32'h1);
        send_line(8);
        chk("t3_next_h", qh(b + 3), 32'd0);
        chk("t3_next_v", qv(b + 3), 32'd1);

        // Overlong line
        do_reset();
        vsync_pulse();
        chk("t4_error_clear", 32'(capture_error), 32'h0);
        b = pix_d.size();
        send_line(10);
        chk("t4_count", 32'(pix_d.size() - b), 32'd4);
        chk("t4_max_h", qh(b + 3), 32'd3);
        chk("t4_error", 32'(capture_error), 32'h1);

        // Final byte edge coincident with VSYNC rise
        do_reset();
        vsync_pulse();
        kbyte = 0;
        b = pix_d.size();
        f = fd_n;
        send_line(8);
        href = 1'b1;
        for (int i = 0; i < 7; i++) send_byte();
        data  = 8'(32'h12 + kbyte * 34);
        kbyte = kbyte + 1;
        pclk  = 1'b0;
        tick(3);
        pclk     = 1'b1;
        vsync    = 1'b1;
        rise_cyc = cyc;
        tick(3);
        pclk = 1'b0;
        href = 1'b0;
        tick(10);
        vsync = 1'b0;
        tick(10);
        chk("t5_count", 32'(pix_d.size() - b), 32'd8);
        chk("t5_last_data", qd(b + 7), 32'hEE10);
        chk("t5_frame_done", 32'(fd_n - f), 32'd1);
        chk("t5_done_gap", 32'(fd_c) - qc(b + 7), 32'd1);

        // Asynchronous reset mid-line
        do_reset();
        vsync_pulse();
        kbyte = 0;
        b = pix_d.size();
        href = 1'b1;
        for (int i = 0; i < 6; i++) send_byte();
        tick(3);
        chk("t6_pre_count", 32'(pix_d.size() - b), 32'd3);
        chk("t6_pre_h", 32'(pixel_hcount), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(pixel_valid), 32'h0);
        chk("t6_rst_data", 32'(pixel_data), 32'h0);
        chk("t6_rst_hcount", 32'(pixel_hcount), 32'h0);
        chk("t6_rst_vcount", 32'(pixel_vcount), 32'h0);
        chk("t6_rst_frame_done", 32'(frame_done), 32'h0);
        chk("t6_rst_error", 32'(capture_error), 32'h0);
        #2 rst = 1'b0;
        href = 1'b0;
        pclk = 1'b0;
        tick(4);
        vsync_pulse();
        kbyte = 0;
        b = pix_d.size();
        send_line(8);
        chk("t6_count", 32'(pix_d.size() - b), 32'd4);
        chk("t6_first_data", qd(b), 32'h1234);
        chk("t6_first_h", qh(b), 32'd0);
        chk("t6_first_v", qv(b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
